// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and defaults for the register file writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int ADDR_W_DEF       = 5;
    localparam int DATA_W_DEF       = 32;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
    typedef logic [DATA_W_DEF-1:0] word_t;

    localparam reg_idx_t X0 = '0;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Busy scoreboard for registers owed by in-flight long-latency ops,
// with a three-port hazard lookup used for the decode stall.
module reg_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDR_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          set_en_i,
    input  logic [ADDRESS_WIDTH-1:0]      set_idx_i,
    input  logic                          clr_en_i,
    input  logic [ADDRESS_WIDTH-1:0]      clr_idx_i,
    input  logic                          mask_en_i,
    input  logic [ADDRESS_WIDTH-1:0]      mask_idx_i,
    input  logic [ADDRESS_WIDTH-1:0]      rs1_i,
    input  logic [ADDRESS_WIDTH-1:0]      rs2_i,
    input  logic [ADDRESS_WIDTH-1:0]      rd_i,
    input  logic                          rd_we_i,
    output logic                          hazard_o,
    output logic [2**ADDRESS_WIDTH-1:0]   busy_o
);

    localparam int N = 2**ADDRESS_WIDTH;

    logic [N-1:0] busy_q;
    logic [N-1:0] busy_d;
    logic [N-1:0] mask_vec;
    logic [N-1:0] busy_eff;

    // Clear is applied before set so a same-cycle issue keeps the entry busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
        if (set_en_i) busy_d[set_idx_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    always_comb begin
        mask_vec = '0;
        if (mask_en_i) mask_vec[mask_idx_i] = 1'b1;
        busy_eff = busy_q & ~mask_vec;
        hazard_o = ((rs1_i != '0) && busy_eff[rs1_i])
                || ((rs2_i != '0) && busy_eff[rs2_i])
                || (rd_we_i && (rd_i != '0) && busy_eff[rd_i]);
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter between pipeline writeback and an LU.
// Optional REGFILE_WB_FAST_CLEAR_EN: hide the accepted LU destination from stall_o.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDR_W_DEF,
    parameter int DATA_WIDTH    = DATA_W_DEF,
    parameter int STARVE_LIMIT  = STARVE_LIMIT_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wb_we_i,
    input  logic [ADDRESS_WIDTH-1:0]      wb_rd_i,
    input  logic [DATA_WIDTH-1:0]         wb_data_i,
    output logic                          wb_hold_o,
    input  logic                          lu_issue_i,
    input  logic [ADDRESS_WIDTH-1:0]      lu_issue_rd_i,
    input  logic                          lu_valid_i,
    input  logic [ADDRESS_WIDTH-1:0]      lu_rd_i,
    input  logic [DATA_WIDTH-1:0]         lu_data_i,
    output logic                          lu_ready_o,
    input  logic [ADDRESS_WIDTH-1:0]      rs1_i,
    input  logic [ADDRESS_WIDTH-1:0]      rs2_i,
    input  logic [ADDRESS_WIDTH-1:0]      rd_i,
    input  logic                          rd_we_i,
    output logic                          stall_o,
    output logic                          we3_o,
    output logic [ADDRESS_WIDTH-1:0]      ad3_o,
    output logic [DATA_WIDTH-1:0]         wd3_o,
    output logic [2**ADDRESS_WIDTH-1:0]   busy_o
);

    logic [3:0] wait_cnt_q;
    logic [3:0] wait_cnt_d;
    logic       wb_active;
    logic       forced;
    logic       lu_accept;
    logic       mask_en;

    // Writeback normally owns the port; a starved LU result takes it by force.
    always_comb begin
        wb_active  = wb_we_i && (wb_rd_i != '0);
        forced     = lu_valid_i && wb_active && (wait_cnt_q == 4'(STARVE_LIMIT));
        lu_ready_o = !wb_active || forced;
        wb_hold_o  = forced;
        lu_accept  = lu_valid_i && lu_ready_o;
        we3_o      = 1'b0;
        ad3_o      = '0;
        wd3_o      = '0;
        if (lu_accept) begin
            we3_o = (lu_rd_i != '0);
            ad3_o = lu_rd_i;
            wd3_o = lu_data_i;
        end else if (wb_active) begin
            we3_o = 1'b1;
            ad3_o = wb_rd_i;
            wd3_o = wb_data_i;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!lu_valid_i || lu_accept)
            wait_cnt_d = '0;
        else if (wait_cnt_q < 4'(STARVE_LIMIT))
            wait_cnt_d = wait_cnt_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) wait_cnt_q <= '0;
        else     wait_cnt_q <= wait_cnt_d;
    end

`ifdef REGFILE_WB_FAST_CLEAR_EN
    assign mask_en = lu_accept;
`else
    assign mask_en = 1'b0;
`endif

    reg_scoreboard #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (lu_issue_i && (lu_issue_rd_i != '0)),
        .set_idx_i  (lu_issue_rd_i),
        .clr_en_i   (lu_accept),
        .clr_idx_i  (lu_rd_i),
        .mask_en_i  (mask_en),
        .mask_idx_i (lu_rd_i),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .rd_i       (rd_i),
        .rd_we_i    (rd_we_i),
        .hazard_o   (stall_o),
        .busy_o     (busy_o)
    );

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Sole owner of the register file write port (WE3/AD3/WD3). Merges the in-order pipeline writeback with results from a long-latency unit (LU, e.g. mul/div) under a valid/ready handshake. Keeps a 32-entry busy scoreboard of registers owed by in-flight LU ops and raises a decode stall on RAW and WAW hazards against them. Sits between the writeback stage, the LU and `regfile`, alongside the hazard unit.

## Interface
- ADDRESS_WIDTH, 5, register index width; 2**ADDRESS_WIDTH scoreboard entries
- DATA_WIDTH, 32, write data width
- STARVE_LIMIT, 4, consecutive cycles an LU result may lose to writeback before forced grant; range 1..15
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- wb_we_i  in  1  pipeline writeback write enable
- wb_rd_i  in  ADDRESS_WIDTH  pipeline destination
- wb_data_i  in  DATA_WIDTH  pipeline write data
- wb_hold_o  out  1  freeze writeback stage this cycle (WB write suppressed)
- lu_issue_i  in  1  LU op issued this cycle
- lu_issue_rd_i  in  ADDRESS_WIDTH  destination of issued LU op
- lu_valid_i  in  1  LU result available
- lu_rd_i  in  ADDRESS_WIDTH  LU result destination
- lu_data_i  in  DATA_WIDTH  LU result data
- lu_ready_o  out  1  LU result accepted this cycle
- rs1_i, rs2_i  in  ADDRESS_WIDTH each  decode source registers
- rd_i  in  ADDRESS_WIDTH  decode destination; rd_we_i  in  1  decode writes rd
- stall_o  out  1  decode hazard stall
- we3_o  out  1, ad3_o  out  ADDRESS_WIDTH, wd3_o  out  DATA_WIDTH  to regfile WE3_i/AD3_i/WD3_i
- busy_o  out  2**ADDRESS_WIDTH  scoreboard, debug

## Operation
- WB request active = wb_we_i && wb_rd_i != 0; LU request = lu_valid_i.
- Default: WB wins. we3_o/ad3_o/wd3_o = WB fields; lu_ready_o = !wb_active.
- wait_cnt (4 bit): increments when lu_valid_i && !lu_ready_o, saturates at STARVE_LIMIT; clears on LU accept or when lu_valid_i low.
- Forced grant: lu_valid_i && wb_active && wait_cnt == STARVE_LIMIT -> wb_hold_o = 1, lu_ready_o = 1, port carries LU fields. Otherwise wb_hold_o = 0.
- No request: we3_o = 0, ad3_o = 0, wd3_o = 0.
- LU must hold lu_valid_i/lu_rd_i/lu_data_i stable until lu_ready_o. LU result to x0: accepted, we3_o = 0.
- Scoreboard: lu_issue_i && lu_issue_rd_i != 0 sets busy[lu_issue_rd_i]; LU accept clears busy[lu_rd_i]. Same register set and cleared in one cycle: set wins. Bit 0 always 0.
- stall_o (combinational) = (rs1_i != 0 && busy[rs1_i]) || (rs2_i != 0 && busy[rs2_i]) || (rd_we_i && rd_i != 0 && busy[rd_i]).
- Issue to an already-busy rd is a protocol error (decode stalls it); scoreboard stays set.

## Timing
- Write-port mux and lu_ready_o/wb_hold_o/stall_o are combinational from inputs and registered state; zero latency to regfile (written on next negedge).
- Busy set visible on stall_o the cycle after issue; clear visible the cycle after accept (see Configuration).
- Worst-case LU acceptance: STARVE_LIMIT+1 cycles after lu_valid_i rises.
- Reset: busy = 0, wait_cnt = 0; outputs then: we3_o 0, lu_ready_o 1 unless WB active, wb_hold_o 0, stall_o 0. Reset mid-handshake drops pending LU state; LU must also reset.

## Configuration
- REGFILE_WB_FAST_CLEAR_EN defined: stall_o masks busy[lu_rd_i] in the cycle the LU result is accepted (regfile negedge write lands before decode read completes), saving one stall cycle.
- Undefined: stall_o uses registered busy only; dependent decode stalls one extra cycle.

## Structure
- Shared package: reg_idx_t, word_t, STARVE_LIMIT default, X0 constant.
- One sub-module: reg_scoreboard (busy array, set/clear, three-port hazard lookup). Arbiter and wait counter in the top.

## Test plan
- Reset, then wb_we_i=1, wb_rd_i=5, wb_data_i=0x1234 -> we3_o=1, ad3_o=5, wd3_o=0x1234, lu_ready_o=0.
- lu_issue_i rd=7; next cycle rs1_i=7 -> stall_o=1; LU returns rd=7 with no WB -> lu_ready_o=1; stall_o=0 next cycle (same cycle with FAST_CLEAR_EN).
- LU valid rd=9 with WB active every cycle, STARVE_LIMIT=4 -> lu_ready_o=0 four cycles, fifth cycle wb_hold_o=1, ad3_o=9, busy[9] clears.
- Issue rd=3 and accept LU rd=3 same cycle -> busy[3]=1 after edge.
- Issue rd=0, WB rd=0 -> busy_o stays 0, we3_o=0; decode rd_we_i=1 rd_i=4 with busy[4] -> stall_o=1 (WAW).
- Assert rst with busy[7], wait_cnt=3 -> next cycle busy_o=0, wb_hold_o=0.
